uart_tx_ctrl: RTL

Frame sequencer for the UART transmitter. It accepts a parallel byte with a Data_Valid strobe and launches the external shift-out serializer. It computes the parity bit and selects the line level for each bit period (start, data, parity, stop). The block sits between the upstream data source and the TX pin, driving TX_OUT and busy; one bit period equals one CLK cycle.

---
 rtl/uart_tx_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: accepts a byte, launches the external serializer and
// selects the line level (start, data, parity, stop) for each one-cycle bit period.

module uart_tx_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic busy,
    input logic ser_en,
    input logic tx_out,
    input logic frame_done
);
    // A load strobe can only come from an idle sequencer.
    a_accept_idle: assert property (@(posedge clk) disable iff (rst) ser_en |-> !busy);
    a_done_in_stop: assert property (@(posedge clk) disable iff (rst) frame_done |-> (busy && tx_out));
    a_low_only_busy: assert property (@(posedge clk) disable iff (rst) !tx_out |-> busy);
    a_reset_idle: assert property (@(posedge clk) rst |=> (!busy && tx_out));
endmodule

module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   par_bit_r;
    logic   par_en_r;
    logic   accept_s;

    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // State register plus the per-frame settings captured at accept time.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            par_bit_r <= 1'b0;
            par_en_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                par_bit_r <= parity_of(P_DATA, PAR_TYP);
                par_en_r  <= PAR_EN;
            end else begin
                par_bit_r <= par_bit_r;
                par_en_r  <= par_en_r;
            end
        end
    end

    // Next-state and line-level selection; unused encodings fall back to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        ser_en      = 1'b0;
        TX_OUT      = 1'b1;
        busy        = 1'b0;
        frame_done  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Reset masks the strobe so no serializer load escapes during reset.
                accept_s = Data_Valid & ~RST;
                ser_en   = accept_s;
                if (Data_Valid) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                TX_OUT      = 1'b0;
                busy        = 1'b1;
                state_nxt_s = ST_DATA;
            end
            ST_DATA: begin
                TX_OUT = ser_data;
                busy   = 1'b1;
                if (!ser_done) begin
                    state_nxt_s = ST_DATA;
                end else if (par_en_r) begin
                    state_nxt_s = ST_PARITY;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_PARITY: begin
                TX_OUT      = par_bit_r;
                busy        = 1'b1;
                state_nxt_s = ST_STOP;
            end
            ST_STOP: begin
                TX_OUT      = 1'b1;
                busy        = 1'b1;
                frame_done  = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    uart_tx_ctrl_chk u_chk (
        .clk        (CLK),
        .rst        (RST),
        .busy       (busy),
        .ser_en     (ser_en),
        .tx_out     (TX_OUT),
        .frame_done (frame_done)
    );

endmodule
